// File: rtl/multiword_add_arb.sv
// Two-requester round-robin front end that serialises W-bit add/subtract through a shared 4-bit adder.
// MULTIWORD_ADD_SUB_MODE_EN enables reqN_sub (a-b); undefined, every operation is a plain add.
module multiword_add_arb #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_sub,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_sub,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_sum,
    output logic                 res_cout,
    output logic                 res_id
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    // state | meaning
    // IDLE  | arbitrate; ready shown to the granted valid requester
    // RUN   | one nibble per cycle through the external adder
    // DONE  | result held until res_ready
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic          ptr;
    logic [KW-1:0] k;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic          grant0;
    logic          grant1;
    logic [3:0]    a_nib;
    logic [3:0]    b_nib;

`ifndef MULTIWORD_ADD_SUB_MODE_EN
    logic unused_sub;
    assign unused_sub = req0_sub | req1_sub;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign a_nib = a_reg[{k, 2'b00} +: 4];
    assign b_nib = b_reg[{k, 2'b00} +: 4];

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_nib;
            add_b   = sub_reg ? ~b_nib : b_nib;
            add_cin = (k == '0) ? sub_reg : carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            k         <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_reg <= grant1 ? req1_a : req0_a;
                        b_reg <= grant1 ? req1_b : req0_b;
`ifdef MULTIWORD_ADD_SUB_MODE_EN
                        sub_reg <= grant1 ? req1_sub : req0_sub;
`else
                        sub_reg <= 1'b0;
`endif
                        res_id <= grant1;
                        ptr    <= grant0;   // next tie goes to the requester just passed over
                        k      <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res_sum[{k, 2'b00} +: 4] <= add_sum;
                    carry <= add_cout;
                    if (k == KW'(NIBBLES - 1)) begin
                        k         <= '0;
                        res_cout  <= add_cout;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_arb.sv
// Randomised bench for multiword_add_arb: models the external adder and predicts results,
// grants and per-nibble adder traffic from plain arithmetic.
module tb_multiword_add_arb;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;
    localparam longint MASK = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_sub, req1_sub;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         res_valid, res_ready, res_cout, res_id;
    logic [W-1:0] res_sum;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m = 0;
    int last_g = 0;

`ifdef MULTIWORD_ADD_SUB_MODE_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    multiword_add_arb #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Runs one transaction end to end; hold = cycles res_ready stays low in DONE.
    task automatic do_op(input bit v0, input bit v1,
                         input logic [W-1:0] a0, input logic [W-1:0] b0, input bit s0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input bit s1,
                         input int hold);
        int g, cyc;
        longint ea, eb, bx, full, mk;
        bit se;
        logic [W-1:0] sum_held;
        req0_valid = v0; req1_valid = v1;
        req0_a = a0; req0_b = b0; req0_sub = s0;
        req1_a = a1; req1_b = b1; req1_sub = s1;
        g = (v0 && (!v1 || ptr_m == 0)) ? 0 : 1;
        #1;
        check("ready0", req0_ready, g == 0);
        check("ready1", req1_ready, g == 1);
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        se = SUB_EN & (g ? s1 : s0);
        bx = se ? (~eb & MASK) : eb;
        full = ea + bx + longint'(se);
        @(posedge clk);
        ptr_m = (g == 0) ? 1 : 0;
        last_g = g;
        #1;
        req0_valid = 0; req1_valid = 0;
        req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom);
        #1;
        check("busy_ready", req0_ready | req1_ready, 0);
        for (cyc = 0; cyc < 3 * NIBBLES; cyc++) begin
            if (res_valid) break;
            if (cyc < NIBBLES) begin
                mk = (64'd1 << (4 * cyc)) - 1;
                check("add_a", add_a, (ea >> (4 * cyc)) & 15);
                check("add_b", add_b, (bx >> (4 * cyc)) & 15);
                check("add_cin", add_cin, (((ea & mk) + (bx & mk) + longint'(se)) >> (4 * cyc)) & 1);
            end
            @(posedge clk); #2;
        end
        check("latency", cyc, NIBBLES);
        check("res_sum", res_sum, full & MASK);
        check("res_cout", res_cout, (full >> W) & 1);
        check("res_id", res_id, g);
        check("idle_adder", {add_a, add_b, add_cin}, 0);
        sum_held = res_sum;
        req0_valid = 1; req1_valid = 1;
        #1;
        for (int h = 0; h <= hold; h++) begin
            check("done_ready", req0_ready | req1_ready, 0);
            check("done_valid", res_valid, 1);
            check("done_sum", res_sum, sum_held);
            check("done_id", res_id, g);
            if (h < hold) begin @(posedge clk); #2; end
        end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        #1;
        check("res_valid_clr", res_valid, 0);
        check("idle_ready_ptr", ptr_m ? req1_ready : req0_ready, 1);
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        int v;
        rst = 1; res_ready = 0;
        req0_valid = 1; req1_valid = 1;
        req0_a = '0; req0_b = '0; req0_sub = 0;
        req1_a = '0; req1_b = '0; req1_sub = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", req0_ready | req1_ready, 0);
        check("rst_valid", res_valid, 0);
        check("rst_sum", res_sum, 0);
        check("rst_cout_id", {res_cout, res_id}, 0);
        check("rst_adder", {add_a, add_b, add_cin}, 0);
        req0_valid = 0; req1_valid = 0;
        rst = 0;
        @(posedge clk); #1;

        // round-robin from reset: 0, 1, 0
        do_op(1, 1, 16'h1234, 16'h4321, 0, 16'h0001, 16'h0002, 0, 0);
        check("rr_first", last_g, 0);
        check("sum_1234_4321", res_sum, 16'h5555);
        do_op(1, 1, 16'h0010, 16'h0020, 0, 16'hFFFF, 16'h0001, 0, 0);
        check("rr_second", last_g, 1);
        check("sum_ffff_0001", {res_cout, res_sum}, 17'h10000);
        do_op(1, 1, 16'h0100, 16'h0200, 0, 16'h0003, 16'h0004, 0, 3);
        check("rr_third", last_g, 0);

        do_op(1, 0, 16'h0005, 16'h0007, 1, 16'h0, 16'h0, 0, 1);
        check("sub_case", {res_cout, res_sum}, SUB_EN ? 17'h0FFFE : 17'h0000C);

        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(1, 3);
            do_op(v[0], v[1], W'($urandom), W'($urandom), 1'($urandom),
                  W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 2));
        end

        // reset during RUN cycle 2 aborts the operation
        req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222;
        @(posedge clk); #1;
        req0_valid = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1;
        @(posedge clk); #1; rst = 0;
        ptr_m = 0;
        v = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (res_valid) v++;
        end
        check("abort_no_result", v, 0);
        check("abort_adder_idle", {add_a, add_b, add_cin}, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("abort_ptr0", {req1_ready, req0_ready}, 2'b01);
        req0_valid = 0; req1_valid = 0;
        do_op(0, 1, 16'h0, 16'h0, 0, 16'hABCD, 16'h1111, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
